// File: rtl/mips_pkg.sv
// Shared MIPS pipeline definitions: datapath defaults, ALU op encoding and
// the operand forward-select enum.
package mips_pkg;

  localparam int DATA_W_DEF  = 32;
  localparam int RADDR_W_DEF = 5;
  localparam int CNT_W_DEF   = 4;

  localparam logic [3:0] ALU_ADD = 4'b0000;
  localparam logic [3:0] ALU_SUB = 4'b0001;
  localparam logic [3:0] ALU_AND = 4'b0010;
  localparam logic [3:0] ALU_OR  = 4'b0011;
  localparam logic [3:0] ALU_XOR = 4'b0100;
  localparam logic [3:0] ALU_NOR = 4'b0101;
  localparam logic [3:0] ALU_SLL = 4'b0110;
  localparam logic [3:0] ALU_SLT = 4'b0111;

  typedef enum logic [1:0] {FWD_RF, FWD_EX, FWD_MEM, FWD_WB} fwd_sel_e;

endpackage

// File: rtl/id_ex_operand_stage_fwd_mux.sv
// Per-operand forwarding: compare the source register against EX/MEM/WB
// destinations and pick the youngest matching result (EX > MEM > WB > regfile).
module fwd_mux
  import mips_pkg::*;
#(
  parameter int DATA_W  = DATA_W_DEF,
  parameter int RADDR_W = RADDR_W_DEF
) (
  input  logic [RADDR_W-1:0] src_i,
  input  logic [DATA_W-1:0]  rf_data_i,
  input  logic               ex_en_i,
  input  logic [RADDR_W-1:0] ex_rd_i,
  input  logic [DATA_W-1:0]  ex_data_i,
  input  logic               mem_en_i,
  input  logic [RADDR_W-1:0] mem_rd_i,
  input  logic [DATA_W-1:0]  mem_data_i,
  input  logic               wb_en_i,
  input  logic [RADDR_W-1:0] wb_rd_i,
  input  logic [DATA_W-1:0]  wb_data_i,
  output logic [DATA_W-1:0]  data_o
);

  fwd_sel_e sel;
  logic     src_zero;

  assign src_zero = (src_i == '0);

  // r0 is hard-wired: never a forwarding target, and its read value is forced to 0.
  always_comb begin
    sel = FWD_RF;
    if (!src_zero) begin
      if (ex_en_i && (ex_rd_i == src_i))        sel = FWD_EX;
      else if (mem_en_i && (mem_rd_i == src_i)) sel = FWD_MEM;
      else if (wb_en_i && (wb_rd_i == src_i))   sel = FWD_WB;
    end
  end

  always_comb begin
    data_o = '0;
    case (sel)
      FWD_EX:  data_o = ex_data_i;
      FWD_MEM: data_o = mem_data_i;
      FWD_WB:  data_o = wb_data_i;
      default: data_o = src_zero ? '0 : rf_data_i;
    endcase
  end

endmodule

// File: rtl/id_ex_operand_stage.sv
// ID/EX pipeline register with operand forwarding, load-use hazard detection
// and bubble insertion; registered outputs feed the ALU and EX/MEM control.
module id_ex_operand_stage
  import mips_pkg::*;
#(
  parameter int DATA_W  = DATA_W_DEF,
  parameter int RADDR_W = RADDR_W_DEF,
  parameter int CNT_W   = CNT_W_DEF
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               id_valid,
  input  logic [RADDR_W-1:0] id_rs,
  input  logic [RADDR_W-1:0] id_rt,
  input  logic [RADDR_W-1:0] id_rd,
  input  logic               id_use_rs,
  input  logic               id_use_rt,
  input  logic [DATA_W-1:0]  id_rs_data,
  input  logic [DATA_W-1:0]  id_rt_data,
  input  logic [DATA_W-1:0]  id_imm,
  input  logic [4:0]         id_shamt,
  input  logic [CNT_W-1:0]   id_alu_cnt,
  input  logic               id_alu_src,
  input  logic               id_reg_write,
  input  logic               id_mem_read,
  input  logic               id_mem_write,
  input  logic               id_mem_to_reg,
  input  logic [DATA_W-1:0]  alu_result,
  input  logic               mem_valid,
  input  logic               mem_reg_write,
  input  logic [RADDR_W-1:0] mem_rd,
  input  logic [DATA_W-1:0]  mem_data,
  input  logic               wb_valid,
  input  logic               wb_reg_write,
  input  logic [RADDR_W-1:0] wb_rd,
  input  logic [DATA_W-1:0]  wb_data,
  input  logic               flush,
  input  logic               ex_hold,
  output logic               stall,
  output logic               ex_valid,
  output logic               ex_reg_write,
  output logic               ex_mem_read,
  output logic               ex_mem_write,
  output logic               ex_mem_to_reg,
  output logic [CNT_W-1:0]   ex_alu_cnt,
  output logic [DATA_W-1:0]  ex_input1,
  output logic [DATA_W-1:0]  ex_input2,
  output logic [DATA_W-1:0]  ex_store_data,
  output logic [4:0]         ex_shamt,
  output logic [RADDR_W-1:0] ex_rd
);

  typedef struct packed {
    logic               valid;
    logic               reg_write;
    logic               mem_read;
    logic               mem_write;
    logic               mem_to_reg;
    logic [CNT_W-1:0]   alu_cnt;
    logic [DATA_W-1:0]  input1;
    logic [DATA_W-1:0]  input2;
    logic [DATA_W-1:0]  store_data;
    logic [4:0]         shamt;
    logic [RADDR_W-1:0] rd;
  } ex_reg_t;

  ex_reg_t            ex_q, ex_d;
  logic [DATA_W-1:0]  fwd_rs, fwd_rt;
  logic               ex_fwd_en, mem_fwd_en, wb_fwd_en;
  logic               hazard;

  // A load in EX has no result yet, so it is excluded from EX forwarding.
  assign ex_fwd_en  = ex_q.valid & ex_q.reg_write & ~ex_q.mem_read;
  assign mem_fwd_en = mem_valid & mem_reg_write;
  assign wb_fwd_en  = wb_valid & wb_reg_write;

  fwd_mux #(.DATA_W(DATA_W), .RADDR_W(RADDR_W)) u_fwd_rs (
    .src_i(id_rs), .rf_data_i(id_rs_data),
    .ex_en_i(ex_fwd_en), .ex_rd_i(ex_q.rd), .ex_data_i(alu_result),
    .mem_en_i(mem_fwd_en), .mem_rd_i(mem_rd), .mem_data_i(mem_data),
    .wb_en_i(wb_fwd_en), .wb_rd_i(wb_rd), .wb_data_i(wb_data),
    .data_o(fwd_rs)
  );

  fwd_mux #(.DATA_W(DATA_W), .RADDR_W(RADDR_W)) u_fwd_rt (
    .src_i(id_rt), .rf_data_i(id_rt_data),
    .ex_en_i(ex_fwd_en), .ex_rd_i(ex_q.rd), .ex_data_i(alu_result),
    .mem_en_i(mem_fwd_en), .mem_rd_i(mem_rd), .mem_data_i(mem_data),
    .wb_en_i(wb_fwd_en), .wb_rd_i(wb_rd), .wb_data_i(wb_data),
    .data_o(fwd_rt)
  );

  assign hazard = id_valid & ex_q.valid & ex_q.mem_read & (ex_q.rd != '0) &
                  ((id_use_rs & (ex_q.rd == id_rs)) | (id_use_rt & (ex_q.rd == id_rt)));

  // ex_hold is not reset, so gate with rst_n to keep stall low during reset.
  assign stall = (hazard | ex_hold) & ~flush & id_valid & rst_n;

  // Hold outranks flush: the instruction already in EX predates the branch.
  always_comb begin
    ex_d = ex_q;
    if (ex_hold) begin
      ex_d = ex_q;
    end else if (flush || hazard || !id_valid) begin
      ex_d = '0;
    end else begin
      ex_d.valid      = 1'b1;
      ex_d.reg_write  = id_reg_write;
      ex_d.mem_read   = id_mem_read;
      ex_d.mem_write  = id_mem_write;
      ex_d.mem_to_reg = id_mem_to_reg;
      ex_d.alu_cnt    = id_alu_cnt;
      ex_d.input1     = fwd_rs;
      ex_d.input2     = id_alu_src ? id_imm : fwd_rt;
      ex_d.store_data = fwd_rt;
      ex_d.shamt      = id_shamt;
      ex_d.rd         = id_rd;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) ex_q <= '0;
    else        ex_q <= ex_d;
  end

  assign ex_valid      = ex_q.valid;
  assign ex_reg_write  = ex_q.reg_write;
  assign ex_mem_read   = ex_q.mem_read;
  assign ex_mem_write  = ex_q.mem_write;
  assign ex_mem_to_reg = ex_q.mem_to_reg;
  assign ex_alu_cnt    = ex_q.alu_cnt;
  assign ex_input1     = ex_q.input1;
  assign ex_input2     = ex_q.input2;
  assign ex_store_data = ex_q.store_data;
  assign ex_shamt      = ex_q.shamt;
  assign ex_rd         = ex_q.rd;

endmodule

// File: tb/tb_id_ex_operand_stage.sv
// Scoreboard bench for id_ex_operand_stage: directed decode vectors push their
// hand-computed EX register contents; a monitor compares them after each edge.
module tb_id_ex_operand_stage;
  import mips_pkg::*;

  logic        clk, rst_n;
  logic        id_valid, id_use_rs, id_use_rt, id_alu_src;
  logic [4:0]  id_rs, id_rt, id_rd, id_shamt;
  logic [31:0] id_rs_data, id_rt_data, id_imm, alu_result;
  logic [3:0]  id_alu_cnt;
  logic        id_reg_write, id_mem_read, id_mem_write, id_mem_to_reg;
  logic        mem_valid, mem_reg_write, wb_valid, wb_reg_write;
  logic [4:0]  mem_rd, wb_rd;
  logic [31:0] mem_data, wb_data;
  logic        flush, ex_hold, stall;
  logic        ex_valid, ex_reg_write, ex_mem_read, ex_mem_write, ex_mem_to_reg;
  logic [3:0]  ex_alu_cnt;
  logic [31:0] ex_input1, ex_input2, ex_store_data;
  logic [4:0]  ex_shamt, ex_rd;

  id_ex_operand_stage #(.DATA_W(32), .RADDR_W(5), .CNT_W(4)) dut (
    .clk(clk), .rst_n(rst_n), .id_valid(id_valid),
    .id_rs(id_rs), .id_rt(id_rt), .id_rd(id_rd),
    .id_use_rs(id_use_rs), .id_use_rt(id_use_rt),
    .id_rs_data(id_rs_data), .id_rt_data(id_rt_data), .id_imm(id_imm),
    .id_shamt(id_shamt), .id_alu_cnt(id_alu_cnt), .id_alu_src(id_alu_src),
    .id_reg_write(id_reg_write), .id_mem_read(id_mem_read),
    .id_mem_write(id_mem_write), .id_mem_to_reg(id_mem_to_reg),
    .alu_result(alu_result),
    .mem_valid(mem_valid), .mem_reg_write(mem_reg_write), .mem_rd(mem_rd), .mem_data(mem_data),
    .wb_valid(wb_valid), .wb_reg_write(wb_reg_write), .wb_rd(wb_rd), .wb_data(wb_data),
    .flush(flush), .ex_hold(ex_hold), .stall(stall),
    .ex_valid(ex_valid), .ex_reg_write(ex_reg_write), .ex_mem_read(ex_mem_read),
    .ex_mem_write(ex_mem_write), .ex_mem_to_reg(ex_mem_to_reg),
    .ex_alu_cnt(ex_alu_cnt), .ex_input1(ex_input1), .ex_input2(ex_input2),
    .ex_store_data(ex_store_data), .ex_shamt(ex_shamt), .ex_rd(ex_rd)
  );

  typedef struct {
    string       name;
    logic        v, rw, mr, mw, m2r;
    logic [3:0]  cnt;
    logic [31:0] in1, in2, st;
    logic [4:0]  sh, rd;
  } exp_t;

  exp_t sb_q[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic exp_t mk(input string name, input logic v, rw, mr, mw, m2r,
                              input logic [3:0] cnt, input logic [31:0] in1, in2, st,
                              input logic [4:0] sh, rd);
    exp_t e;
    e.name = name; e.v = v; e.rw = rw; e.mr = mr; e.mw = mw; e.m2r = m2r;
    e.cnt = cnt; e.in1 = in1; e.in2 = in2; e.st = st; e.sh = sh; e.rd = rd;
    return e;
  endfunction

  function automatic exp_t bubble(input string name);
    return mk(name, 0, 0, 0, 0, 0, 4'h0, 32'h0, 32'h0, 32'h0, 5'd0, 5'd0);
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_tests++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %h want %h", name, act, req);
    end
  endtask

  // Monitor: each falling edge, compare the EX register against the oldest expectation.
  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      if (sb_q.size() > 0) begin
        e = sb_q.pop_front();
        n_tests++;
        if ({ex_valid, ex_reg_write, ex_mem_read, ex_mem_write, ex_mem_to_reg, ex_alu_cnt,
             ex_input1, ex_input2, ex_store_data, ex_shamt, ex_rd} !==
            {e.v, e.rw, e.mr, e.mw, e.m2r, e.cnt, e.in1, e.in2, e.st, e.sh, e.rd}) begin
          n_fail++;
          $display("FAIL %s: got v=%0b rw=%0b mr=%0b mw=%0b m2r=%0b cnt=%0h in1=%h in2=%h st=%h sh=%0d rd=%0d; want v=%0b rw=%0b mr=%0b mw=%0b m2r=%0b cnt=%0h in1=%h in2=%h st=%h sh=%0d rd=%0d",
                   e.name, ex_valid, ex_reg_write, ex_mem_read, ex_mem_write, ex_mem_to_reg,
                   ex_alu_cnt, ex_input1, ex_input2, ex_store_data, ex_shamt, ex_rd,
                   e.v, e.rw, e.mr, e.mw, e.m2r, e.cnt, e.in1, e.in2, e.st, e.sh, e.rd);
        end
      end
    end
  end

  task automatic instr(input logic [4:0] rs, rt, rd, input logic urs, urt,
                       input logic [31:0] rsd, rtd, imm, input logic [3:0] cnt,
                       input logic src, rw, mr, mw, m2r, input logic [4:0] sh);
    id_valid = 1'b1; id_rs = rs; id_rt = rt; id_rd = rd; id_use_rs = urs; id_use_rt = urt;
    id_rs_data = rsd; id_rt_data = rtd; id_imm = imm; id_alu_cnt = cnt; id_alu_src = src;
    id_reg_write = rw; id_mem_read = mr; id_mem_write = mw; id_mem_to_reg = m2r; id_shamt = sh;
  endtask

  task automatic set_mem(input logic v, input logic [4:0] rd, input logic [31:0] d);
    mem_valid = v; mem_reg_write = v; mem_rd = rd; mem_data = d;
  endtask

  task automatic set_wb(input logic v, input logic [4:0] rd, input logic [31:0] d);
    wb_valid = v; wb_reg_write = v; wb_rd = rd; wb_data = d;
  endtask

  // Called at negedge+1 with inputs applied: check stall, queue the post-edge state.
  task automatic step(input exp_t e, input logic exp_stall);
    #1 chk({e.name, "_stall"}, {31'b0, stall}, {31'b0, exp_stall});
    sb_q.push_back(e);
    @(negedge clk);
    #1;
  endtask

  exp_t x_held;

  initial begin
    rst_n = 1'b0; flush = 1'b0; ex_hold = 1'b1; alu_result = '0;
    instr(5'd1, 5'd2, 5'd3, 1, 1, 32'h5, 32'h7, 32'h0, ALU_ADD, 0, 1, 0, 0, 0, 5'd0);
    set_mem(0, 5'd0, 32'h0); set_wb(0, 5'd0, 32'h0);
    @(negedge clk); #1;
    chk("rst_valid", {31'b0, ex_valid}, 32'h0);
    chk("rst_input1", ex_input1, 32'h0);
    chk("rst_rd", {27'b0, ex_rd}, 32'h0);
    chk("rst_stall", {31'b0, stall}, 32'h0);
    rst_n = 1'b1; ex_hold = 1'b0; id_valid = 1'b0;
    step(bubble("idle"), 0);

    // ADD r3=r1+r2, then SUB r4=r3-r1 forwarded from EX
    instr(5'd1, 5'd2, 5'd3, 1, 1, 32'h5, 32'h7, 32'h0, ALU_ADD, 0, 1, 0, 0, 0, 5'd0);
    step(mk("add", 1, 1, 0, 0, 0, ALU_ADD, 32'h5, 32'h7, 32'h7, 5'd0, 5'd3), 0);
    alu_result = 32'd12;
    instr(5'd3, 5'd1, 5'd4, 1, 1, 32'h0, 32'h5, 32'h0, ALU_SUB, 0, 1, 0, 0, 0, 5'd0);
    step(mk("sub_exfwd", 1, 1, 0, 0, 0, ALU_SUB, 32'd12, 32'h5, 32'h5, 5'd0, 5'd4), 0);

    // LW r5,16(r1) then ADD r6=r5+r5: one bubble, then MEM forward
    alu_result = 32'h7;
    instr(5'd1, 5'd5, 5'd5, 1, 0, 32'h5, 32'h99, 32'h10, ALU_ADD, 1, 1, 1, 0, 1, 5'd0);
    step(mk("lw", 1, 1, 1, 0, 1, ALU_ADD, 32'h5, 32'h10, 32'h99, 5'd0, 5'd5), 0);
    alu_result = 32'h15;
    instr(5'd5, 5'd5, 5'd6, 1, 1, 32'h3, 32'h3, 32'h0, ALU_ADD, 0, 1, 0, 0, 0, 5'd0);
    step(bubble("lu_bubble"), 1);
    set_mem(1, 5'd5, 32'h0000_00AA);
    step(mk("lu_memfwd", 1, 1, 0, 0, 0, ALU_ADD, 32'hAA, 32'hAA, 32'hAA, 5'd0, 5'd6), 0);

    // MEM beats WB on r7; r0 reads 0 and is never forwarded
    alu_result = 32'h154;
    set_mem(1, 5'd7, 32'h11); set_wb(1, 5'd7, 32'h22);
    instr(5'd7, 5'd0, 5'd8, 1, 1, 32'h3, 32'h55, 32'h0, ALU_OR, 0, 1, 0, 0, 0, 5'd0);
    step(mk("mem_over_wb", 1, 1, 0, 0, 0, ALU_OR, 32'h11, 32'h0, 32'h0, 5'd0, 5'd8), 0);
    set_mem(1, 5'd0, 32'h33);
    instr(5'd0, 5'd7, 5'd9, 1, 1, 32'h66, 32'h44, 32'h0, ALU_AND, 0, 1, 0, 0, 0, 5'd0);
    step(mk("r0_wbfwd", 1, 1, 0, 0, 0, ALU_AND, 32'h0, 32'h22, 32'h22, 5'd0, 5'd9), 0);
    set_mem(0, 5'd0, 32'h0);
    instr(5'd1, 5'd7, 5'd0, 1, 1, 32'h5, 32'h44, 32'h4, ALU_ADD, 1, 0, 0, 1, 0, 5'd0);
    step(mk("sw_imm", 1, 0, 0, 1, 0, ALU_ADD, 32'h5, 32'h4, 32'h22, 5'd0, 5'd0), 0);
    set_wb(0, 5'd0, 32'h0);

    // flush -> bubble; flush under hold -> frozen, no stall
    flush = 1'b1;
    instr(5'd1, 5'd2, 5'd3, 1, 1, 32'h1, 32'h2, 32'h0, ALU_ADD, 0, 1, 0, 0, 0, 5'd0);
    step(bubble("flush"), 0);
    flush = 1'b0;
    instr(5'd1, 5'd2, 5'd10, 1, 1, 32'h3, 32'h4, 32'h0, ALU_OR, 0, 1, 0, 0, 0, 5'd3);
    x_held = mk("x_cap", 1, 1, 0, 0, 0, ALU_OR, 32'h3, 32'h4, 32'h4, 5'd3, 5'd10);
    step(x_held, 0);
    alu_result = 32'h7;
    flush = 1'b1; ex_hold = 1'b1;
    instr(5'd10, 5'd2, 5'd0, 1, 1, 32'h0, 32'h4, 32'h0, ALU_SLT, 0, 1, 0, 0, 0, 5'd0);
    x_held.name = "flush_hold";
    step(x_held, 0);

    // hold 3 cycles, then the held instruction is captured exactly once
    flush = 1'b0;
    for (int i = 0; i < 3; i++) begin
      x_held.name = $sformatf("hold%0d", i);
      step(x_held, 1);
    end
    ex_hold = 1'b0;
    step(mk("hold_release", 1, 1, 0, 0, 0, ALU_SLT, 32'h7, 32'h4, 32'h4, 5'd0, 5'd0), 0);
    alu_result = 32'h1;
    instr(5'd0, 5'd0, 5'd11, 1, 0, 32'h77, 32'h0, 32'h5, ALU_ADD, 1, 1, 0, 0, 0, 5'd0);
    step(mk("rd0_nofwd", 1, 1, 0, 0, 0, ALU_ADD, 32'h0, 32'h5, 32'h0, 5'd0, 5'd11), 0);
    id_valid = 1'b0;
    step(bubble("no_valid"), 0);

    // reset during a load-use stall
    instr(5'd1, 5'd0, 5'd12, 1, 0, 32'h8, 32'h0, 32'h4, ALU_ADD, 1, 1, 1, 0, 1, 5'd0);
    step(mk("lw2", 1, 1, 1, 0, 1, ALU_ADD, 32'h8, 32'h4, 32'h0, 5'd0, 5'd12), 0);
    instr(5'd12, 5'd0, 5'd13, 1, 0, 32'h0, 32'h0, 32'h0, ALU_ADD, 0, 1, 0, 0, 0, 5'd0);
    #1 chk("pre_rst_stall", {31'b0, stall}, 32'h1);
    sb_q.push_back(bubble("in_reset"));
    #1 rst_n = 1'b0;
    #1 chk("async_rst_valid", {31'b0, ex_valid}, 32'h0);
    chk("async_rst_memread", {31'b0, ex_mem_read}, 32'h0);
    chk("async_rst_rd", {27'b0, ex_rd}, 32'h0);
    chk("async_rst_stall", {31'b0, stall}, 32'h0);
    @(negedge clk); #1;
    rst_n = 1'b1;
    id_rs_data = 32'h21;
    step(mk("post_rst_cap", 1, 1, 0, 0, 0, ALU_ADD, 32'h21, 32'h0, 32'h0, 5'd0, 5'd13), 0);
    id_valid = 1'b0;

    chk("sb_drained", sb_q.size(), 32'h0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
